// File: rtl/xosera_bus_pkg.sv
// Shared types for the Xosera 8-bit register bus initiator.
package xosera_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } bus_state_t;

  typedef enum logic {
    RnW_WRITE = 1'b0,
    RnW_READ  = 1'b1
  } RnW_t;

  typedef enum logic {
    cs_ENABLED  = 1'b0,
    cs_DISABLED = 1'b1
  } cs_n_t;

  localparam logic BYTESEL_EVEN = 1'b0;
  localparam logic BYTESEL_ODD  = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xosera_bus_initiator.sv
// Host-side initiator for the Xosera 8-bit register bus: one 16-bit request becomes up to two byte cycles.
// Reads are only supported when XOSERA_BUS_READ_EN is defined; otherwise every request is a write.
module xosera_bus_initiator
  import xosera_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [1:0]  req_bytes_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

  bus_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          odd_q, odd_d;

  RnW_t        rd_q, req_rnw, lat_rd;
  logic [3:0]  reg_q, lat_reg;
  logic [1:0]  bytes_q;
  logic [15:0] data_q, lat_data;
  logic        accept, enter_setup, bus_active_d;

`ifdef XOSERA_BUS_READ_EN
  assign req_rnw = req_rd_nwr_i ? RnW_READ : RnW_WRITE;
`else
  logic unused_read_inputs;
  assign req_rnw            = RnW_WRITE;
  assign unused_read_inputs = ^{req_rd_nwr_i, bus_data_i};
`endif

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_ready_o && req_valid_i;

  // The first byte is set up straight from the request inputs; later bytes use the latched copy.
  assign lat_rd   = (state_q == IDLE) ? req_rnw       : rd_q;
  assign lat_reg  = (state_q == IDLE) ? req_reg_num_i : reg_q;
  assign lat_data = (state_q == IDLE) ? req_data_i    : data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bytes_i == 2'b00) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LOAD;
            odd_d   = req_bytes_i[1] ? BYTESEL_EVEN : BYTESEL_ODD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (odd_q == BYTESEL_EVEN && bytes_q[0]) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          odd_d   = BYTESEL_ODD;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      odd_q   <= BYTESEL_EVEN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_q    <= RnW_WRITE;
      reg_q   <= '0;
      bytes_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      rd_q    <= req_rnw;
      reg_q   <= req_reg_num_i;
      bytes_q <= req_bytes_i;
      data_q  <= req_data_i;
    end
  end

  assign enter_setup  = (state_d == SETUP) && (state_q != SETUP);
  assign bus_active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      bus_cs_n_o    <= cs_DISABLED;
      bus_rd_nwr_o  <= RnW_WRITE;
      bus_bytesel_o <= BYTESEL_EVEN;
      bus_reg_num_o <= '0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
      rsp_valid_o   <= 1'b0;
    end else begin
      bus_cs_n_o    <= (state_d == STROBE) ? cs_ENABLED : cs_DISABLED;
      bus_data_oe_o <= bus_active_d && (lat_rd == RnW_WRITE);
      rsp_valid_o   <= (state_d == DONE);
      if (enter_setup) begin
        bus_rd_nwr_o  <= lat_rd;
        bus_bytesel_o <= odd_d;
        bus_reg_num_o <= lat_reg;
        bus_data_o    <= (odd_d == BYTESEL_ODD) ? lat_data[7:0] : lat_data[15:8];
      end
    end
  end

`ifdef XOSERA_BUS_READ_EN
  logic [15:0] rd_shadow_q;

  // Each byte is captured at the end of its strobe; disabled bytes keep the zero loaded on accept.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_shadow_q <= '0;
    end else if (accept) begin
      rd_shadow_q <= '0;
    end else if (state_q == STROBE && cnt_q == '0 && rd_q == RnW_READ) begin
      if (odd_q == BYTESEL_ODD) rd_shadow_q[7:0]  <= bus_data_i;
      else                      rd_shadow_q[15:8] <= bus_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rsp_data_o <= '0;
    end else if (state_d == DONE && lat_rd == RnW_READ) begin
      rsp_data_o <= (state_q == IDLE) ? 16'h0000 : rd_shadow_q;
    end
  end
`else
  assign rsp_data_o = 16'h0000;
`endif

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Self-checking bench for xosera_bus_initiator; a scoreboard predicts bus byte cycles and responses.
// Works with or without XOSERA_BUS_READ_EN defined.
module tb_xosera_bus_initiator;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;

  logic        clk;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_rd_nwr_i;
  logic [3:0]  req_reg_num_i;
  logic [1:0]  req_bytes_i;
  logic [15:0] req_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic        bus_bytesel_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;
  logic [7:0]  tgt_even, tgt_odd;

  xosera_bus_initiator #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_rd_nwr_i (req_rd_nwr_i),
    .req_reg_num_i(req_reg_num_i),
    .req_bytes_i  (req_bytes_i),
    .req_data_i   (req_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .bus_cs_n_o   (bus_cs_n_o),
    .bus_rd_nwr_o (bus_rd_nwr_o),
    .bus_bytesel_o(bus_bytesel_o),
    .bus_reg_num_o(bus_reg_num_o),
    .bus_data_o   (bus_data_o),
    .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i   (bus_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_data_i = bus_bytesel_o ? tgt_odd : tgt_even;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_exp_t;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       rd;
    logic [3:0] reg_n;
  } byte_exp_t;

  rsp_exp_t  rsp_q[$];
  byte_exp_t byte_q[$];
  byte_exp_t cur_byte;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rsp_count = 0;
  int          strobe_count = 0;
  int          strobe_len = 0;
  int          last_accept = 0;
  logic        in_strobe = 1'b0;
  logic        prev_oe = 1'b0;
  logic [15:0] model_rsp = 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExpected();
    logic      rd;
    int        nb;
    byte_exp_t b;
    rsp_exp_t  r;
`ifdef XOSERA_BUS_READ_EN
    rd = req_rd_nwr_i;
`else
    rd = 1'b0;
`endif
    nb = int'(req_bytes_i[1]) + int'(req_bytes_i[0]);
    if (req_bytes_i[1]) begin
      b = '{sel: 1'b0, data: req_data_i[15:8], rd: rd, reg_n: req_reg_num_i};
      byte_q.push_back(b);
    end
    if (req_bytes_i[0]) begin
      b = '{sel: 1'b1, data: req_data_i[7:0], rd: rd, reg_n: req_reg_num_i};
      byte_q.push_back(b);
    end
    if (rd) model_rsp = {req_bytes_i[1] ? tgt_even : 8'h00, req_bytes_i[0] ? tgt_odd : 8'h00};
    r = '{data: model_rsp, due: cyc + 1 + nb * (S + T + H)};
    rsp_q.push_back(r);
    last_accept = cyc;
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_i) begin
      rsp_q.delete();
      byte_q.delete();
      in_strobe  = 1'b0;
      strobe_len = 0;
      model_rsp  = 16'h0000;
    end else begin
      if (req_valid_i && req_ready_o) pushExpected();
      if (rsp_valid_o) begin
        rsp_exp_t e;
        rsp_count++;
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 1, 0);
        end else begin
          e = rsp_q.pop_front();
          checkOutput("rsp_data", rsp_data_o, e.data);
          checkOutput("rsp_latency", cyc, e.due);
        end
      end
      if (!bus_cs_n_o) begin
        if (bus_data_oe_o != prev_oe) checkOutput("oe_change_in_strobe", 1, 0);
        if (!in_strobe) begin
          in_strobe  = 1'b1;
          strobe_len = 0;
          strobe_count++;
          if (byte_q.size() == 0) begin
            checkOutput("strobe_unexpected", 1, 0);
            cur_byte = '{sel: 1'b0, data: 8'h00, rd: 1'b0, reg_n: 4'h0};
          end else begin
            cur_byte = byte_q.pop_front();
            checkOutput("strobe_bytesel", bus_bytesel_o, cur_byte.sel);
            checkOutput("strobe_rd_nwr", bus_rd_nwr_o, cur_byte.rd);
            checkOutput("strobe_reg_num", bus_reg_num_o, cur_byte.reg_n);
            checkOutput("strobe_oe", bus_data_oe_o, !cur_byte.rd);
            if (!cur_byte.rd) checkOutput("strobe_data", bus_data_o, cur_byte.data);
          end
        end
        strobe_len++;
      end else if (in_strobe) begin
        in_strobe = 1'b0;
        checkOutput("strobe_len", strobe_len, T);
        checkOutput("hold_bytesel", bus_bytesel_o, cur_byte.sel);
        checkOutput("hold_oe", bus_data_oe_o, !cur_byte.rd);
        if (!cur_byte.rd) checkOutput("hold_data", bus_data_o, cur_byte.data);
      end
      prev_oe = bus_data_oe_o;
    end
  end

  task automatic applyStimulus(input logic rd, input logic [3:0] reg_n, input logic [1:0] bytes,
                               input logic [15:0] data, input logic keep);
    bit done;
    @(posedge clk);
    #1;
    req_rd_nwr_i  = rd;
    req_reg_num_i = reg_n;
    req_bytes_i   = bytes;
    req_data_i    = data;
    req_valid_i   = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready_o) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) req_valid_i = 1'b0;
  endtask

  task automatic waitRsp(input int target);
    for (int i = 0; i < 60 && rsp_count < target; i++) @(negedge clk);
    #1;
    checkOutput("rsp_seen", rsp_count >= target, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, base, s0;
    reset_i       = 1'b1;
    req_valid_i   = 1'b0;
    req_rd_nwr_i  = 1'b0;
    req_reg_num_i = 4'h0;
    req_bytes_i   = 2'b00;
    req_data_i    = 16'h0000;
    tgt_even      = 8'h12;
    tgt_odd       = 8'h34;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cs_n", bus_cs_n_o, 1);
    checkOutput("reset_oe", bus_data_oe_o, 0);
    checkOutput("reset_rd_nwr", bus_rd_nwr_o, 0);
    checkOutput("reset_bytesel", bus_bytesel_o, 0);
    checkOutput("reset_reg_num", bus_reg_num_o, 0);
    checkOutput("reset_data", bus_data_o, 0);
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_rsp_data", rsp_data_o, 0);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", req_ready_o, 1);

    $display("[TB] two-byte write");
    applyStimulus(1'b0, 4'h3, 2'b11, 16'hA55A, 1'b0);
    waitRsp(1);

    $display("[TB] two-byte read");
    applyStimulus(1'b1, 4'h9, 2'b11, 16'h0000, 1'b0);
    waitRsp(2);

    $display("[TB] odd-only write and empty mask");
    applyStimulus(1'b0, 4'h5, 2'b01, 16'hBEEF, 1'b0);
    waitRsp(3);
    s0 = strobe_count;
    applyStimulus(1'b0, 4'h6, 2'b00, 16'h1234, 1'b0);
    waitRsp(4);
    checkOutput("empty_mask_no_strobe", strobe_count, s0);

    $display("[TB] back-to-back writes");
    applyStimulus(1'b0, 4'h1, 2'b11, 16'h1357, 1'b1);
    c1 = last_accept;
    applyStimulus(1'b0, 4'h2, 2'b11, 16'h2468, 1'b0);
    checkOutput("b2b_gap", last_accept - c1, 2 + 2 * (S + T + H));
    waitRsp(6);
    repeat (15) @(negedge clk);
    checkOutput("b2b_pulses", rsp_count, 6);

    $display("[TB] reset during strobe");
    applyStimulus(1'b0, 4'h7, 2'b11, 16'hC3C3, 1'b0);
    for (int i = 0; i < 20 && bus_cs_n_o; i++) @(negedge clk);
    checkOutput("abort_strobe_seen", bus_cs_n_o, 0);
    #1 reset_i = 1'b1;
    @(negedge clk);
    checkOutput("abort_cs_n", bus_cs_n_o, 1);
    checkOutput("abort_oe", bus_data_oe_o, 0);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", req_ready_o, 1);
    base = rsp_count;
    repeat (15) @(negedge clk);
    checkOutput("abort_no_rsp", rsp_count, base);

    $display("[TB] read request reg 2 and even-only read");
    tgt_even = 8'h56;
    tgt_odd  = 8'h78;
    applyStimulus(1'b1, 4'h2, 2'b11, 16'h0102, 1'b0);
    waitRsp(base + 1);
    applyStimulus(1'b1, 4'hA, 2'b10, 16'h0000, 1'b0);
    waitRsp(base + 2);
    applyStimulus(1'b0, 4'hB, 2'b10, 16'h9900, 1'b0);
    waitRsp(base + 3);

    repeat (5) @(negedge clk);
    checkOutput("rsp_queue_empty", rsp_q.size(), 0);
    checkOutput("byte_queue_empty", byte_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
